// File: rtl/ast_tensor_pkg.sv
// Shared types for the tensor host sequencer: FSM state encoding, the
// default dimension type and a helper that validates one matrix dimension.
package ast_tensor_pkg;

    localparam int SIZE_DEFAULT = 4;
    localparam int DIM_W        = $clog2(SIZE_DEFAULT) + 1;

    typedef logic [DIM_W-1:0] dim_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        START,
        WAIT,
        DRAIN,
        FIN
    } seq_state_e;

    // A dimension is usable when it is between 1 and the array size
    function automatic logic dim_ok(input logic [31:0] d, input int size);
        return (d != 32'd0) && (d <= 32'(size));
    endfunction

endpackage

// File: rtl/ast_seq_addr_gen_sv.sv
// Nested row/column walker producing base + row*stride + col addresses.
// Reloaded once per phase (A read, B read, X write); 'last' flags the final
// element of the current walk. Addresses wrap modulo 2^ADDRWIDTH.
module ast_seq_addr_gen_sv #(
    parameter int ADDRWIDTH = 10,
    parameter int DW        = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic [ADDRWIDTH-1:0] base,
    input  logic [DW-1:0]        stride,
    input  logic [DW-1:0]        rows,
    input  logic [DW-1:0]        cols,
    output logic [ADDRWIDTH-1:0] addr,
    output logic                 last
);

    logic [DW-1:0]        row_q, row_d;
    logic [DW-1:0]        col_q, col_d;
    logic [DW-1:0]        rows_q, rows_d;
    logic [DW-1:0]        cols_q, cols_d;
    logic [DW-1:0]        stride_q, stride_d;
    logic [ADDRWIDTH-1:0] row_base_q, row_base_d;

    assign addr = row_base_q + ADDRWIDTH'(col_q);
    assign last = (row_q == rows_q - DW'(1)) && (col_q == cols_q - DW'(1));

    // Reload takes priority over stepping; column wraps into the next row
    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        row_base_d = row_base_q;
        if (load) begin
            row_d      = '0;
            col_d      = '0;
            rows_d     = rows;
            cols_d     = cols;
            stride_d   = stride;
            row_base_d = base;
        end else if (step) begin
            if (col_q == cols_q - DW'(1)) begin
                col_d      = '0;
                row_d      = row_q + DW'(1);
                row_base_d = row_base_q + ADDRWIDTH'(stride_q);
            end else begin
                col_d = col_q + DW'(1);
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q      <= '0;
            col_q      <= '0;
            rows_q     <= '0;
            cols_q     <= '0;
            stride_q   <= '0;
            row_base_q <= '0;
        end else begin
            row_q      <= row_d;
            col_q      <= col_d;
            rows_q     <= rows_d;
            cols_q     <= cols_d;
            stride_q   <= stride_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/ast_tensor_host_sequencer_sv.sv
// Host-side sequencer for one matmul X = A*B on the tensor system: streams A
// then B from scratch memory, pulses start, waits for done, then drains the
// QxK result back to memory row-major.
// Optional: define AST_SEQ_PERF_EN to add the perf_cycles counter output.
module ast_tensor_host_sequencer_sv
    import ast_tensor_pkg::*;
#(
    parameter int DATAWIDTH = 14,
    parameter int SIZE      = 4,
    parameter int ADDRWIDTH = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(SIZE):0]    cmd_q,
    input  logic [$clog2(SIZE):0]    cmd_r,
    input  logic [$clog2(SIZE):0]    cmd_k,
    input  logic [ADDRWIDTH-1:0]     cmd_base_a,
    input  logic [ADDRWIDTH-1:0]     cmd_base_b,
    input  logic [ADDRWIDTH-1:0]     cmd_base_x,
    input  logic                     cmd_relu,
    output logic                     mem_ren,
    output logic [ADDRWIDTH-1:0]     mem_raddr,
    input  logic [DATAWIDTH-1:0]     mem_rdata,
    output logic                     mem_wen,
    output logic [ADDRWIDTH-1:0]     mem_waddr,
    output logic [DATAWIDTH-1:0]     mem_wdata,
    output logic                     ts_wen,
    output logic                     ts_set,
    output logic [$clog2(SIZE):0]    ts_depth,
    output logic [$clog2(SIZE):0]    ts_width,
    output logic [DATAWIDTH-1:0]     ts_data_in,
    output logic                     ts_relu,
    output logic                     ts_start,
    input  logic                     ts_busy,
    input  logic                     ts_done,
    output logic                     ts_ren,
    input  logic [DATAWIDTH-1:0]     ts_data_out,
    output logic                     seq_done,
    output logic                     cmd_err
`ifdef AST_SEQ_PERF_EN
    ,
    output logic [15:0]              perf_cycles
`endif
);

    localparam int DW = $clog2(SIZE) + 1;

    seq_state_e           state_q, state_d;
    logic [DW-1:0]        q_q, q_d, r_q, r_d, k_q, k_d;
    logic [ADDRWIDTH-1:0] base_b_q, base_b_d, base_x_q, base_x_d;
    logic                 relu_q, relu_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 rd_set_q, rd_set_d;
    logic                 reads_done_q, reads_done_d;

    logic                 cmd_fire, dims_ok, accept_ok;
    logic                 ag_load, ag_step, ag_last;
    logic [ADDRWIDTH-1:0] ag_base, ag_addr;
    logic [DW-1:0]        ag_stride, ag_rows, ag_cols;

    assign cmd_ready = (state_q == IDLE) && !ts_busy;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign dims_ok   = dim_ok(32'(cmd_q), SIZE) && dim_ok(32'(cmd_r), SIZE) && dim_ok(32'(cmd_k), SIZE);
    assign accept_ok = cmd_fire && dims_ok;

    // Data read last cycle is pushed now; width/depth follow the matrix being pushed
    assign ts_wen     = rd_valid_q;
    assign ts_set     = rd_set_q;
    assign ts_data_in = rd_valid_q ? mem_rdata : '0;
    assign ts_width   = !rd_valid_q ? '0 : (rd_set_q ? r_q : q_q);
    assign ts_depth   = !rd_valid_q ? '0 : (rd_set_q ? k_q : r_q);
    assign ts_relu    = (state_q != IDLE) && relu_q;
    assign cmd_err    = cmd_err_q;

    ast_seq_addr_gen_sv #(
        .ADDRWIDTH (ADDRWIDTH),
        .DW        (DW)
    ) u_addr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (ag_load),
        .step   (ag_step),
        .base   (ag_base),
        .stride (ag_stride),
        .rows   (ag_rows),
        .cols   (ag_cols),
        .addr   (ag_addr),
        .last   (ag_last)
    );

    // Phase sequencing: next state, strobes and address-generator reloads
    always_comb begin
        state_d      = state_q;
        q_d          = q_q;
        r_d          = r_q;
        k_d          = k_q;
        base_b_d     = base_b_q;
        base_x_d     = base_x_q;
        relu_d       = relu_q;
        cmd_err_d    = 1'b0;
        rd_valid_d   = 1'b0;
        rd_set_d     = 1'b0;
        reads_done_d = reads_done_q;
        ag_load      = 1'b0;
        ag_step      = 1'b0;
        ag_base      = '0;
        ag_stride    = '0;
        ag_rows      = '0;
        ag_cols      = '0;
        mem_ren      = 1'b0;
        mem_raddr    = '0;
        mem_wen      = 1'b0;
        mem_waddr    = '0;
        mem_wdata    = '0;
        ts_start     = 1'b0;
        ts_ren       = 1'b0;
        seq_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_ok) begin
                    q_d          = cmd_q;
                    r_d          = cmd_r;
                    k_d          = cmd_k;
                    base_b_d     = cmd_base_b;
                    base_x_d     = cmd_base_x;
                    relu_d       = cmd_relu;
                    reads_done_d = 1'b0;
                    ag_load      = 1'b1;
                    ag_base      = cmd_base_a;
                    ag_stride    = cmd_r;
                    ag_rows      = cmd_q;
                    ag_cols      = cmd_r;
                    state_d      = LOAD_A;
                end else if (cmd_fire) begin
                    cmd_err_d = 1'b1;
                end
            end
            LOAD_A: begin
                mem_ren    = 1'b1;
                mem_raddr  = ag_addr;
                ag_step    = 1'b1;
                rd_valid_d = 1'b1;
                if (ag_last) begin
                    ag_load   = 1'b1;
                    ag_base   = base_b_q;
                    ag_stride = k_q;
                    ag_rows   = r_q;
                    ag_cols   = k_q;
                    state_d   = LOAD_B;
                end
            end
            LOAD_B: begin
                if (!reads_done_q) begin
                    mem_ren    = 1'b1;
                    mem_raddr  = ag_addr;
                    ag_step    = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_set_d   = 1'b1;
                    if (ag_last) begin
                        reads_done_d = 1'b1;
                    end
                end else begin
                    state_d = START;
                end
            end
            START: begin
                ts_start = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (ts_done) begin
                    ag_load   = 1'b1;
                    ag_base   = base_x_q;
                    ag_stride = k_q;
                    ag_rows   = q_q;
                    ag_cols   = k_q;
                    state_d   = DRAIN;
                end
            end
            DRAIN: begin
                ts_ren    = 1'b1;
                mem_wen   = 1'b1;
                mem_waddr = ag_addr;
                mem_wdata = ts_data_out;
                ag_step   = 1'b1;
                if (ag_last) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                seq_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and command registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            q_q          <= '0;
            r_q          <= '0;
            k_q          <= '0;
            base_b_q     <= '0;
            base_x_q     <= '0;
            relu_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_set_q     <= 1'b0;
            reads_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            q_q          <= q_d;
            r_q          <= r_d;
            k_q          <= k_d;
            base_b_q     <= base_b_d;
            base_x_q     <= base_x_d;
            relu_q       <= relu_d;
            cmd_err_q    <= cmd_err_d;
            rd_valid_q   <= rd_valid_d;
            rd_set_q     <= rd_set_d;
            reads_done_q <= reads_done_d;
        end
    end

`ifdef AST_SEQ_PERF_EN
    logic [15:0] perf_cycles_q, perf_cycles_d;

    assign perf_cycles = perf_cycles_q;

    // Count start-through-done cycles, saturating, cleared by each accept
    always_comb begin
        perf_cycles_d = perf_cycles_q;
        if (accept_ok) begin
            perf_cycles_d = '0;
        end else if (((state_q == START) || (state_q == WAIT)) && (perf_cycles_q != 16'hFFFF)) begin
            perf_cycles_d = perf_cycles_q + 16'd1;
        end
    end

    // Perf counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_cycles_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
        end
    end
`endif

endmodule

// File: tb/tb_ast_tensor_host_sequencer_sv.sv
// Self-checking bench for ast_tensor_host_sequencer_sv: scratch memory model,
// a behavioural tensor system, and a scoreboard of expected memory writes.
module tb_ast_tensor_host_sequencer_sv;

    localparam int DATAWIDTH = 14;
    localparam int SIZE      = 4;
    localparam int ADDRWIDTH = 10;
    localparam int DW        = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 cmd_valid, cmd_ready, cmd_relu;
    logic [DW-1:0]        cmd_q, cmd_r, cmd_k;
    logic [ADDRWIDTH-1:0] cmd_base_a, cmd_base_b, cmd_base_x;
    logic                 mem_ren, mem_wen;
    logic [ADDRWIDTH-1:0] mem_raddr, mem_waddr;
    logic [DATAWIDTH-1:0] mem_rdata = '0;
    logic [DATAWIDTH-1:0] mem_wdata;
    logic                 ts_wen, ts_set, ts_relu, ts_start, ts_busy, ts_ren, seq_done, cmd_err;
    logic                 ts_done = 1'b0;
    logic [DW-1:0]        ts_depth, ts_width;
    logic [DATAWIDTH-1:0] ts_data_in, ts_data_out;

    typedef struct {
        logic [ADDRWIDTH-1:0] addr;
        logic [DATAWIDTH-1:0] data;
    } wr_t;

    wr_t  expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   exp_q, exp_r, exp_k;
    int   push_cnt, ren_cnt, start_cnt, first_rd, start_cyc, first_push, last_push, last_wr;
    int   act_cnt = 0;
    int   err_cnt = 0;
    bit   done_seen;

    always #5 clk = ~clk;

    ast_tensor_host_sequencer_sv #(
        .DATAWIDTH (DATAWIDTH),
        .SIZE      (SIZE),
        .ADDRWIDTH (ADDRWIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_q       (cmd_q),
        .cmd_r       (cmd_r),
        .cmd_k       (cmd_k),
        .cmd_base_a  (cmd_base_a),
        .cmd_base_b  (cmd_base_b),
        .cmd_base_x  (cmd_base_x),
        .cmd_relu    (cmd_relu),
        .mem_ren     (mem_ren),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .mem_wen     (mem_wen),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .ts_wen      (ts_wen),
        .ts_set      (ts_set),
        .ts_depth    (ts_depth),
        .ts_width    (ts_width),
        .ts_data_in  (ts_data_in),
        .ts_relu     (ts_relu),
        .ts_start    (ts_start),
        .ts_busy     (ts_busy),
        .ts_done     (ts_done),
        .ts_ren      (ts_ren),
        .ts_data_out (ts_data_out),
        .seq_done    (seq_done),
        .cmd_err     (cmd_err)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Truncate an accumulated dot product to element width and apply ReLU
    function automatic logic [DATAWIDTH-1:0] finishElem(input int acc, input logic relu);
        logic [DATAWIDTH-1:0] t;
        t = acc[DATAWIDTH-1:0];
        if (relu && t[DATAWIDTH-1]) t = '0;
        return t;
    endfunction

    function automatic int sext(input logic [DATAWIDTH-1:0] v);
        int s;
        s = $signed(v);
        return s;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scratch memory: read data valid the cycle after the strobe
    logic [DATAWIDTH-1:0] mem [0:1023];
    always @(posedge clk) if (mem_ren) mem_rdata <= mem[mem_raddr];

    // Behavioural tensor system: collect pushes, compute on start, done after a delay, FIFO pop
    logic [DATAWIDTH-1:0] ma [0:15];
    logic [DATAWIDTH-1:0] mb [0:15];
    logic [DATAWIDTH-1:0] mres [0:15];
    int ma_n, mb_n, mq, mr, mk, mhead, mdelay;

    function automatic logic [DATAWIDTH-1:0] modelElem(input int i, input int j);
        int acc = 0;
        for (int t = 0; t < mr; t++) acc += sext(ma[(i*mr + t) & 15]) * sext(mb[(t*mk + j) & 15]);
        return finishElem(acc, ts_relu);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            ma_n <= 0; mb_n <= 0; mhead <= 0; mdelay <= 0; ts_done <= 1'b0;
        end else begin
            ts_done <= 1'b0;
            if (ts_wen) begin
                if (!ts_set) begin
                    ma[ma_n & 15] <= ts_data_in; ma_n <= ma_n + 1;
                    mq <= int'(ts_width); mr <= int'(ts_depth);
                end else begin
                    mb[mb_n & 15] <= ts_data_in; mb_n <= mb_n + 1;
                    mk <= int'(ts_depth);
                end
            end
            if (ts_start) begin
                for (int i = 0; i < mq; i++)
                    for (int j = 0; j < mk; j++)
                        mres[(i*mk + j) & 15] <= modelElem(i, j);
                mhead <= 0; ma_n <= 0; mb_n <= 0; mdelay <= 4;
            end
            if (mdelay > 0) begin
                mdelay <= mdelay - 1;
                if (mdelay == 1) ts_done <= 1'b1;
            end
            if (ts_ren) mhead <= mhead + 1;
        end
    end
    assign ts_data_out = mres[mhead & 15];

    // Monitor at the falling edge: push ordering, scoreboard writes, event timing
    always @(negedge clk) begin
        logic exp_set;
        wr_t  e;
        if (!reset) begin
            if (mem_ren || mem_wen || ts_wen || ts_start || ts_ren) act_cnt++;
            if (cmd_err) err_cnt++;
            if (mem_ren && first_rd < 0) first_rd = cyc;
            if (ts_start) begin start_cyc = cyc; start_cnt++; end
            if (ts_wen) begin
                exp_set = (push_cnt >= exp_q * exp_r);
                checkOutput("push_set", 32'(ts_set), 32'(exp_set));
                checkOutput("push_width", 32'(ts_width), exp_set ? exp_r : exp_q);
                checkOutput("push_depth", 32'(ts_depth), exp_set ? exp_k : exp_r);
                if (push_cnt == 0) first_push = cyc;
                last_push = cyc;
                push_cnt++;
            end
            if (ts_ren) ren_cnt++;
            if (mem_wen) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wr_addr", 32'(mem_waddr), 32'(e.addr));
                    checkOutput("wr_data", 32'(mem_wdata), 32'(e.data));
                end
                last_wr = cyc;
            end
            if (seq_done) begin
                done_seen = 1'b1;
                checkOutput("done_after_write", cyc - last_wr, 32'd1);
            end
        end
    end

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_strobes"}, 32'({mem_ren, mem_wen, ts_wen, ts_start, ts_ren, seq_done, cmd_err}), 32'd0);
        checkOutput({tag, "_addrdata"}, 32'({mem_raddr, mem_waddr, mem_wdata, ts_data_in}), 32'd0);
        checkOutput({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    // Predict the writes from memory contents, then present the command for one cycle
    task automatic issueCmd(input int q, input int r, input int k, input logic [ADDRWIDTH-1:0] ba,
                            input logic [ADDRWIDTH-1:0] bb, input logic [ADDRWIDTH-1:0] bx, input logic relu);
        wr_t w;
        int  acc;
        exp_q = q; exp_r = r; exp_k = k;
        for (int i = 0; i < q; i++)
            for (int j = 0; j < k; j++) begin
                acc = 0;
                for (int t = 0; t < r; t++)
                    acc += sext(mem[ADDRWIDTH'(ba + i*r + t)]) * sext(mem[ADDRWIDTH'(bb + t*k + j)]);
                w.addr = ADDRWIDTH'(bx + i*k + j);
                w.data = finishElem(acc, relu);
                expQ.push_back(w);
            end
        push_cnt = 0; ren_cnt = 0; start_cnt = 0; first_rd = -1; start_cyc = -1;
        first_push = -1; last_push = -1; last_wr = -100; done_seen = 1'b0;
        @(posedge clk); #1;
        checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_q = DW'(q); cmd_r = DW'(r); cmd_k = DW'(k);
        cmd_base_a = ba; cmd_base_b = bb; cmd_base_x = bx; cmd_relu = relu;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        int qr = exp_q * exp_r;
        int rk = exp_r * exp_k;
        while (!done_seen && n < 600) begin @(negedge clk); n++; end
        checkOutput("seq_done_seen", 32'(done_seen), 32'd1);
        repeat (2) @(negedge clk);
        checkOutput("push_count", push_cnt, qr + rk);
        checkOutput("push_contiguous", last_push - first_push, qr + rk - 1);
        checkOutput("load_latency", start_cyc - first_rd, qr + rk + 1);
        checkOutput("start_count", start_cnt, 32'd1);
        checkOutput("ren_count", ren_cnt, exp_q * exp_k);
        checkOutput("writes_left", expQ.size(), 32'd0);
    endtask

    task automatic applyStimulus(input int q, input int r, input int k, input logic [ADDRWIDTH-1:0] ba,
                                 input logic [ADDRWIDTH-1:0] bb, input logic [ADDRWIDTH-1:0] bx, input logic relu);
        issueCmd(q, r, k, ba, bb, bx, relu);
        waitDone();
    endtask

    task automatic rejectCmd(input int q, input int r, input int k);
        int act0, err0;
        @(posedge clk); #1;
        act0 = act_cnt; err0 = err_cnt;
        cmd_q = DW'(q); cmd_r = DW'(r); cmd_k = DW'(k); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reject_err_pulse", err_cnt - err0, 32'd1);
        checkOutput("reject_no_activity", act_cnt - act0, 32'd0);
        checkOutput("reject_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic resetDuring(input bit inDrain);
        int n = 0;
        bit hit = 0;
        issueCmd(3, 3, 3, 10'h200, 10'h220, 10'h240, 1'b0);
        while (!hit && n < 300) begin
            @(negedge clk); n++;
            if (inDrain ? ts_ren : (ts_wen && ts_set)) hit = 1;
        end
        checkOutput(inDrain ? "reach_drain" : "reach_load_b", 32'(hit), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkIdleOutputs(inDrain ? "rst_drain" : "rst_load_b");
        reset = 1'b0;
        expQ.delete();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_relu = 1'b0; ts_busy = 1'b0;
        cmd_q = '0; cmd_r = '0; cmd_k = '0;
        cmd_base_a = '0; cmd_base_b = '0; cmd_base_x = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DATAWIDTH'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(negedge clk);
        checkIdleOutputs("after_reset");

        ts_busy = 1'b1;
        #1 checkOutput("ready_busy", 32'(cmd_ready), 32'd0);
        ts_busy = 1'b0;

        // 2x2x2 reference product
        mem[0] = 14'd1; mem[1] = 14'd2; mem[2] = 14'd3; mem[3] = 14'd4;
        mem[16] = 14'd5; mem[17] = 14'd6; mem[18] = 14'd7; mem[19] = 14'd8;
        applyStimulus(2, 2, 2, 10'h000, 10'h010, 10'h020, 1'b0);

        // 1x1x1 with a negative result, ReLU on then off
        mem[10'h040] = 14'd3; mem[10'h041] = 14'h3FFE;
        applyStimulus(1, 1, 1, 10'h040, 10'h041, 10'h050, 1'b1);
        applyStimulus(1, 1, 1, 10'h040, 10'h041, 10'h050, 1'b0);

        // 4x3x2 with a stray command while busy
        issueCmd(4, 3, 2, 10'h080, 10'h0A0, 10'h0C0, 1'b0);
        repeat (3) @(posedge clk);
        #1 cmd_q = 3'd1; cmd_r = 3'd1; cmd_k = 3'd1; cmd_valid = 1'b1;
        @(posedge clk); #1 cmd_valid = 1'b0;
        waitDone();

        // Illegal dimensions
        rejectCmd(2, 2, 0);
        rejectCmd(5, 2, 2);

        // Reset in the middle of loading and draining, then a clean command
        resetDuring(1'b0);
        resetDuring(1'b1);
        applyStimulus(3, 2, 4, 10'h300, 10'h310, 10'h320, 1'b1);

        // Write address wrap at the top of memory
        applyStimulus(2, 2, 2, 10'h100, 10'h110, 10'h3FE, 1'b0);

        // Random shapes and placements
        for (int t = 0; t < 4; t++)
            applyStimulus(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)),
                          ADDRWIDTH'($urandom), ADDRWIDTH'($urandom), ADDRWIDTH'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
